// File: rtl/button_event_queue.sv
// Four-button synchroniser/debouncer feeding a small colour-event FIFO read at address 7.
// Define BTN_TIMESTAMP_EN to store a prescaled free-running timestamp with each event.
module button_event_queue #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int FIFO_DEPTH      = 4,
   parameter int TS_SHIFT        = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          red_button,
   input  logic                          blue_button,
   input  logic                          green_button,
   input  logic                          yellow_button,
   input  logic                          rd_en,
   output logic [31:0]                   rd_data,
   output logic [3:0]                    btn_level,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

   localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

   logic [3:0]       raw_buttons;
   logic [3:0]       level_d_reg;
   logic [3:0]       pending_reg;
   logic [3:0]       pending_next;
   logic [3:0]       rise;
   logic [3:0]       push_onehot;
   logic [1:0]       push_sel;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic             drop;
   logic             full;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [OCC_W-1:0] count_reg;
   logic [OCC_W-1:0] count_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic [1:0]       color_mem [FIFO_DEPTH];
   logic [1:0]       head_color;
   logic [15:0]      head_ts;

   assign raw_buttons = {yellow_button, green_button, blue_button, red_button};

   // Per-button two-flop synchroniser and level debouncer
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         logic [1:0]       sync_reg;
         logic             lvl_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               sync_reg <= 2'b00;
               lvl_reg  <= 1'b0;
               cnt_reg  <= '0;
            end else begin
               sync_reg <= {sync_reg[0], raw_buttons[gi]};
               if (sync_reg[1] == lvl_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  lvl_reg <= ~lvl_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign btn_level[gi] = lvl_reg;
      end
   endgenerate

   assign rise = btn_level & ~level_d_reg;

   // Lowest pending index wins: red > blue > green > yellow
   always_comb begin
      push_sel = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (pending_reg[i]) push_sel = 2'(i);
      end
   end

   assign push_req     = |pending_reg;
   assign push_onehot  = push_req ? (4'b0001 << push_sel) : 4'b0000;
   assign pending_next = (pending_reg & ~push_onehot) | rise;

   // A pop on a full queue frees the slot the simultaneous push needs
   assign full    = (count_reg == OCC_FULL);
   assign pop     = rd_en && (count_reg != '0);
   assign push_ok = push_req && (!full || rd_en);
   assign drop    = push_req && full && !rd_en;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop)      count_next = count_reg + 1'b1;
      else if (!push_ok && pop) count_next = count_reg - 1'b1;
   end

   assign ovf_next = drop ? 1'b1 : (rd_en ? 1'b0 : ovf_reg);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         level_d_reg <= 4'b0;
         pending_reg <= 4'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         ovf_reg     <= 1'b0;
      end else begin
         level_d_reg <= btn_level;
         pending_reg <= pending_next;
         count_reg   <= count_next;
         ovf_reg     <= ovf_next;
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) color_mem[wr_ptr_reg] <= push_sel;
   end

   assign head_color = (count_reg != '0) ? color_mem[rd_ptr_reg] : 2'b00;

`ifdef BTN_TIMESTAMP_EN
   logic [TS_SHIFT+15:0] free_cnt_reg;
   logic [15:0]          ts_mem [FIFO_DEPTH];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) free_cnt_reg <= '0;
      else       free_cnt_reg <= free_cnt_reg + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (push_ok) ts_mem[wr_ptr_reg] <= free_cnt_reg[TS_SHIFT+15:TS_SHIFT];
   end

   assign head_ts = (count_reg != '0) ? ts_mem[rd_ptr_reg] : 16'h0;
`else
   assign head_ts = 16'h0;
`endif

   assign rd_data  = {head_ts, 12'b0, ovf_reg, head_color, (count_reg != '0)};
   assign ev_count = count_reg;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomised scoreboard bench for button_event_queue with a queue-level reference model.
module tb_button_event_queue;
   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        red_button = 1'b0, blue_button = 1'b0, green_button = 1'b0, yellow_button = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic [3:0]  btn_level;
   logic [2:0]  ev_count;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      int          count;
   } exp_t;

   exp_t     exp_q[$];
   exp_t     mon_e;
   bit [1:0] model_q[$];
   bit       model_ovf = 1'b0;

   button_event_queue #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .TS_SHIFT(2)) dut (
      .clock(clock), .reset(reset),
      .red_button(red_button), .blue_button(blue_button),
      .green_button(green_button), .yellow_button(yellow_button),
      .rd_en(rd_en), .rd_data(rd_data), .btn_level(btn_level), .ev_count(ev_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_buttons(input logic [3:0] m);
      {yellow_button, green_button, blue_button, red_button} = m;
   endtask

   // Simultaneous presses enqueue in colour-priority order; surplus events set ovf
   task automatic model_press(input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            if (model_q.size() < DEPTH) model_q.push_back(2'(i));
            else model_ovf = 1'b1;
         end
      end
   endtask

   task automatic model_read(output exp_t e);
      e.count = model_q.size();
      if (model_q.size() > 0) begin
         e.data = {28'b0, model_ovf, model_q[0], 1'b1};
         void'(model_q.pop_front());
      end else begin
         e.data = {28'b0, model_ovf, 3'b000};
      end
      model_ovf = 1'b0;
   endtask

   task automatic do_read();
      exp_t e;
      model_read(e);
      exp_q.push_back(e);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      tick(1);
      $display("read: expected data=%h count=%0d", e.data, e.count);
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      model_press(m);
      set_buttons(m);
      tick(hold);
      check("level_held", 32'(btn_level), 32'(m));
      set_buttons(4'b0);
      tick(D + 12);
      check("level_released", 32'(btn_level), 32'h0);
      $display("press: mask=%h hold=%0d queued=%0d ovf=%0d", m, hold, model_q.size(), model_ovf);
   endtask

   task automatic glitch(input logic [3:0] m, input int len);
      set_buttons(m);
      tick(len);
      set_buttons(4'b0);
      tick(D + 4);
      check("glitch_level", 32'(btn_level), 32'h0);
      check("glitch_count", 32'(ev_count), 32'(model_q.size()));
      $display("glitch: mask=%h len=%0d", m, len);
   endtask

   // Monitor: every read strobe is compared against the next scoreboard entry
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (!reset && rd_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_read actual=%h required=no read", rd_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("read_data", rd_data, mon_e.data);
               check("read_count", 32'(ev_count), 32'(mon_e.count));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [3:0] m;

      tick(3);
      reset = 1'b0;
      tick(3);
      check("idle_rd_data", rd_data, 32'h0);
      check("idle_ev_count", 32'(ev_count), 32'h0);
      check("idle_btn_level", 32'(btn_level), 32'h0);

      // Green press: valid exactly 2 + D + 2 edges after the raw edge
      model_press(4'b0100);
      green_button = 1'b1;
      tick(7);
      check("green_not_yet", 32'(rd_data[0]), 32'h0);
      tick(1);
      check("green_latency", rd_data, 32'h5);
      tick(12);
      green_button = 1'b0;
      tick(D + 12);
      do_read();
      check("green_after_pop", rd_data, 32'h0);
      check("green_after_pop_cnt", 32'(ev_count), 32'h0);

      // Short red glitch never reaches btn_level
      red_button = 1'b1;
      tick(2);
      red_button = 1'b0;
      tick(4);
      check("red_glitch_level", 32'(btn_level[0]), 32'h0);
      tick(8);
      check("red_glitch_count", 32'(ev_count), 32'h0);

      // All four together
      press(4'hF, D + 4);
      check("all_four_count", 32'(ev_count), 32'h4);
      check("all_four_head", rd_data, 32'h1);
      repeat (4) do_read();

      // Five blue presses with no reads -> overflow
      repeat (5) press(4'b0010, D + 3);
      check("five_blue_count", 32'(ev_count), 32'h4);
      check("five_blue_head", rd_data, 32'hB);
      repeat (4) do_read();

      // Full queue, read strobe on the same edge as a new push
      press(4'b0001, D + 3);
      press(4'b0010, D + 3);
      press(4'b0100, D + 3);
      press(4'b1000, D + 3);
      blue_button = 1'b1;
      tick(7);
      model_read(e);
      model_q.push_back(2'd1);
      exp_q.push_back(e);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check("full_push_pop_count", 32'(ev_count), 32'h4);
      check("full_push_pop_ovf", 32'(rd_data[3]), 32'h0);
      blue_button = 1'b0;
      tick(D + 12);
      while (model_q.size() > 0) do_read();

      // Randomised mix
      repeat (80) begin
         case ($urandom_range(0, 3))
            0, 1: begin
               m = 4'($urandom_range(1, 15));
               press(m, D + 2 + $urandom_range(0, 6));
            end
            2: begin
               m = 4'($urandom_range(1, 15));
               glitch(m, $urandom_range(1, D - 1));
            end
            default: do_read();
         endcase
      end
      while (model_q.size() > 0) do_read();
      do_read();

      // Asynchronous reset in the middle of a debounce with a non-empty queue
      press(4'b0001, D + 3);
      check("pre_reset_count", 32'(ev_count), 32'h1);
      green_button = 1'b1;
      tick(3);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_rd_data", rd_data, 32'h0);
      check("async_reset_count", 32'(ev_count), 32'h0);
      check("async_reset_level", 32'(btn_level), 32'h0);
      model_q.delete();
      model_ovf = 1'b0;
      set_buttons(4'b0);
      @(negedge clock);
      reset = 1'b0;
      tick(D + 12);
      check("post_reset_rd_data", rd_data, 32'h0);
      check("post_reset_count", 32'(ev_count), 32'h0);

      tick(2);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
